configurable_mock_rng: RTL and testbench
========================================

# configurable_mock_rng

Parametrised, multi-mode mock entropy source for exercising downstream conditioning and health-test logic. It generalises the fixed mock sources into one block with four selectable modes: alternating, repeating pattern, LFSR, and user-fed FIFO. It also adds a valid/ready handshake so generators advance only when a bit is consumed. It sits in the position of a real RNG, driving `entropy_valid`/`entropy_bit` into the entropy consumer.

## Interface

Parameters:

- `PATTERN_WIDTH`, 16: length of the repeating pattern (≥2).
- `PATTERN`, 16'b1111110111100101: repeating pattern, emitted LSB first.
- `LFSR_WIDTH`, 16: LFSR length (≥3).
- `LFSR_TAPS`, 16'hB400: Fibonacci feedback mask.
- `LFSR_SEED`, 16'h0001: LFSR reset value. An all-zero seed is replaced by 1.
- `FIFO_DEPTH`, 8: user FIFO depth (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-high):

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  2  0 = alternating, 1 = pattern, 2 = LFSR, 3 = user FIFO.
- `user_valid`  in  1  user bit offered.
- `user_bit`  in  1  user data bit.
- `user_ready`  out  1  FIFO can accept a bit (= !full).
- `entropy_ready`  in  1  consumer accepts the current bit.
- `entropy_valid`  out  1  current bit valid.
- `entropy_bit`  out  1  current entropy bit.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky: a user bit was offered while full.

## Operation

- Consume event: `entropy_valid && entropy_ready` at a rising edge. Only the generator selected by `mode` advances, and only on a consume. All other generators hold state.
- Mode 0: 1-bit toggle state. `entropy_bit` = state; state inverts on consume. `entropy_valid` = 1.
- Mode 1: index `idx` of width $clog2(PATTERN_WIDTH).
  - `entropy_bit` = `PATTERN[idx]`.
  - On consume, idx increments and wraps PATTERN_WIDTH-1 → 0.
  - `entropy_valid` = 1.
- Mode 2: Fibonacci LFSR `s`.
  - `entropy_bit` = `s[LFSR_WIDTH-1]`.
  - On consume, `s <= {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)}`.
  - `entropy_valid` = 1.
  - The default taps give maximal period 65535; all-zero state is unreachable.
- Mode 3: `entropy_valid` = !empty; `entropy_bit` = FIFO head, or 0 when empty.
  - On consume, the head is popped.
  - No bypass: a bit pushed into an empty FIFO is first visible the cycle after the push.
- FIFO push (any mode): `user_valid && user_ready` at an edge writes `user_bit`.
  - The FIFO fills while other modes are selected and is not flushed on a mode change.
- Simultaneous push and pop, not full and not empty: both occur; level unchanged.
  - When full, push is refused (`user_ready` = 0) even if a pop occurs the same cycle.
- Overflow: `user_valid && !user_ready` at an edge sets `overflow`. It clears only on `rst`.
- `mode` is sampled each cycle, with no registering. Changing it switches outputs combinationally to the retained state of the newly selected generator.

## Timing

- All outputs are combinational from registered state plus `mode`. There is zero latency from a mode change to the outputs.
- Generators advance exactly one step per consume. They stall indefinitely while `entropy_ready` = 0, with the bit held stable.
- FIFO latency: pushed at edge N → visible at outputs after edge N (cycle N+1); pop-to-next-head is the same.
- Reset (async assert, takes effect immediately, also mid-stream):
  - toggle = 0;
  - idx = 0;
  - s = LFSR_SEED (or 1 if the seed is 0);
  - FIFO empty, `fifo_level` = 0;
  - `overflow` = 0;
  - `user_ready` = 1.
- Output values in reset, per mode:
  - mode 0: `entropy_bit` = 0;
  - mode 1: `entropy_bit` = PATTERN[0];
  - mode 3: `entropy_valid` = 0.

## Test plan

- Reset, mode 0, `entropy_ready` = 1 for 6 cycles → `entropy_bit` 0,1,0,1,0,1; `entropy_valid` constantly 1.
- Mode 1 defaults, ready = 1 for 32 cycles → 1,0,1,0,0,1,1,1,1,0,1,1,1,1,1,1, repeated twice (wrap after index 15).
- Mode 1, consume 3 bits, then hold `entropy_ready` = 0 for 5 cycles → `entropy_bit` stays 0 (PATTERN[3]); the next consume yields 0 (PATTERN[3]), then 0 (PATTERN[4]).
- Mode 2 with seed 1, ready = 1:
  - `entropy_bit` = 0 for the first 15 consumes, 1 on the 16th;
  - after 65535 consumes the state equals 16'h0001 again, never reaching zero.
- Mode 3, ready = 0, push 10 alternating bits starting 1:
  - `user_ready` drops after 8 pushes;
  - `fifo_level` = 8; `overflow` = 1 from the 9th offer.
  - Then with ready = 1, drain → 1,0,1,0,1,0,1,0, after which `entropy_valid` drops to 0 and `fifo_level` = 0.
- Mode 1, consume 5 bits, switch to mode 0 for 2 consumes, back to mode 1 → the next bit is PATTERN[5] = 1.
  - Assert `rst` asynchronously mid-cycle → the outputs immediately return to reset values.

Source files
------------

// File: rtl/configurable_mock_rng.sv
// configurable_mock_rng: multi-mode mock entropy source
// (alternating, pattern, LFSR, user FIFO) with valid/ready output.
module configurable_mock_rng #(
  parameter int                      PATTERN_WIDTH = 16,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 16'b1111110111100101,
  parameter int                      LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0]   LFSR_TAPS     = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0]   LFSR_SEED     = 16'h0001,
  parameter int                      FIFO_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic                        user_valid,
  input  logic                        user_bit,
  output logic                        user_ready,
  input  logic                        entropy_ready,
  output logic                        entropy_valid,
  output logic                        entropy_bit,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int IW = $clog2(PATTERN_WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_WIDTH-1:0] SEED =
    (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;
  localparam logic [IW-1:0] IDX_LAST = IW'(PATTERN_WIDTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic                  toggle;
  logic [IW-1:0]         idx;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [FIFO_DEPTH-1:0] mem;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [LW-1:0]         level;

  logic empty;
  logic full;
  logic consume;
  logic push;
  logic pop;
  logic fb;

  assign empty      = (level == '0);
  assign full       = (level == LVL_FULL);
  assign user_ready = !full;
  assign fifo_level = level;
  assign consume    = entropy_valid && entropy_ready;
  assign push       = user_valid && !full;
  assign pop        = consume && (mode == 2'd3);
  assign fb         = ^(lfsr & LFSR_TAPS);

  // Output mux: selected generator's current state, no registering of mode.
  always_comb begin
    entropy_valid = 1'b1;
    entropy_bit   = 1'b0;
    unique case (mode)
      2'd0: entropy_bit = toggle;
      2'd1: entropy_bit = PATTERN[idx];
      2'd2: entropy_bit = lfsr[LFSR_WIDTH-1];
      2'd3: begin
        entropy_valid = !empty;
        entropy_bit   = !empty && mem[rd_ptr];
      end
    endcase
  end

  // Generators: only the selected one steps, once per consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= 1'b0;
      idx    <= '0;
      lfsr   <= SEED;
    end else if (consume) begin
      unique case (mode)
        2'd0: toggle <= !toggle;
        2'd1: idx    <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        2'd2: lfsr   <= {lfsr[LFSR_WIDTH-2:0], fb};
        2'd3: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= user_bit;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (user_valid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_configurable_mock_rng.sv
// tb_configurable_mock_rng: directed scoreboard bench for
// configurable_mock_rng with default parameters.
module tb_configurable_mock_rng;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       user_valid;
  logic       user_bit;
  logic       user_ready;
  logic       entropy_ready;
  logic       entropy_valid;
  logic       entropy_bit;
  logic [3:0] fifo_level;
  logic       overflow;

  configurable_mock_rng dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .user_valid    (user_valid),
    .user_bit      (user_bit),
    .user_ready    (user_ready),
    .entropy_ready (entropy_ready),
    .entropy_valid (entropy_valid),
    .entropy_bit   (entropy_bit),
    .fifo_level    (fifo_level),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  bit          sb[$];
  bit          mon_exp;
  int          checks = 0;
  int          errors = 0;
  logic [0:15] pat_seq = 16'b1010011110111111;
  logic [15:0] m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input logic [1:0] md, input bit e);
    mode          = md;
    entropy_ready = 1'b1;
    sb.push_back(e);
    #1;
    chk("valid_on_take", entropy_valid, 1);
    tick();
    entropy_ready = 1'b0;
  endtask

  // Monitor: every consume pops one expected bit from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && entropy_valid && entropy_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_consume: got bit %0d, expected none",
                   entropy_bit);
        end else begin
          mon_exp = sb.pop_front();
          if (entropy_bit !== mon_exp) begin
            errors++;
            $display("FAIL stream_bit: got %0d, expected %0d",
                     entropy_bit, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    mode          = 2'd0;
    user_valid    = 1'b0;
    user_bit      = 1'b0;
    entropy_ready = 1'b0;
    #2;
    chk("rst_m0_bit", entropy_bit, 0);
    chk("rst_m0_valid", entropy_valid, 1);
    mode = 2'd1;
    #1 chk("rst_m1_bit", entropy_bit, 1);
    mode = 2'd3;
    #1 chk("rst_m3_valid", entropy_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_user_ready", user_ready, 1);
    tick();
    rst = 1'b0;

    // Alternating
    for (int i = 0; i < 6; i++) take(2'd0, bit'(i % 2));

    // Pattern, two full periods
    for (int i = 0; i < 32; i++) take(2'd1, pat_seq[i % 16]);

    // Pattern stall
    for (int i = 0; i < 3; i++) take(2'd1, pat_seq[i]);
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_hold", entropy_bit, 0);
      tick();
    end
    take(2'd1, 1'b0);
    take(2'd1, 1'b0);

    // Mode switch keeps pattern index (idx = 5)
    take(2'd0, 1'b0);
    take(2'd0, 1'b1);
    mode = 2'd1;
    #1 chk("pattern_resume", entropy_bit, 1);
    take(2'd1, 1'b1);

    // LFSR full period, then the seed sequence repeats
    m = 16'h0001;
    for (int i = 0; i < 65535; i++) begin
      take(2'd2, m[15]);
      m = {m[14:0], ^(m & 16'hB400)};
    end
    for (int i = 0; i < 16; i++) take(2'd2, bit'(i == 15));

    // FIFO fill with consumer stalled
    mode = 2'd3;
    for (int i = 0; i < 10; i++) begin
      user_valid = 1'b1;
      user_bit   = (i % 2 == 0);
      #1;
      if (i == 0) chk("no_bypass", entropy_valid, 0);
      chk("fill_user_ready", user_ready, (i < 8) ? 1 : 0);
      tick();
      chk("fill_level", fifo_level, (i < 8) ? i + 1 : 8);
      chk("fill_overflow", overflow, (i >= 8) ? 1 : 0);
    end
    user_valid = 1'b0;

    // First drain beat offers a push while full: refused
    user_valid = 1'b1;
    user_bit   = 1'b0;
    take(2'd3, 1'b1);
    user_valid = 1'b0;
    chk("full_push_refused", fifo_level, 7);
    for (int i = 1; i < 8; i++) take(2'd3, bit'(i % 2 == 0));
    #1;
    chk("drain_valid", entropy_valid, 0);
    chk("drain_level", fifo_level, 0);
    chk("drain_bit", entropy_bit, 0);
    chk("overflow_sticky", overflow, 1);

    // Simultaneous push and pop
    user_valid = 1'b1;
    user_bit   = 1'b1;
    tick();
    chk("pp_level_a", fifo_level, 1);
    user_bit = 1'b0;
    take(2'd3, 1'b1);
    user_valid = 1'b0;
    chk("pp_level_b", fifo_level, 1);
    take(2'd3, 1'b0);
    chk("pp_level_c", fifo_level, 0);

    // Async reset mid-cycle (idx 6 -> 9, toggle -> 1, one FIFO bit)
    take(2'd1, pat_seq[6]);
    take(2'd1, pat_seq[7]);
    take(2'd1, pat_seq[8]);
    take(2'd0, 1'b0);
    user_valid = 1'b1;
    user_bit   = 1'b1;
    tick();
    user_valid = 1'b0;
    mode = 2'd1;
    #1 chk("pre_reset_bit", entropy_bit, 0);
    chk("pre_reset_level", fifo_level, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_m1_bit", entropy_bit, 1);
    chk("async_level", fifo_level, 0);
    chk("async_overflow", overflow, 0);
    chk("async_user_ready", user_ready, 1);
    mode = 2'd0;
    #1 chk("async_m0_bit", entropy_bit, 0);
    mode = 2'd3;
    #1 chk("async_m3_valid", entropy_valid, 0);
    tick();
    rst = 1'b0;
    take(2'd0, 1'b0);
    take(2'd1, 1'b1);
    take(2'd1, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
